// File: rtl/array_walk_pkg.sv
// Shared state encoding, walk modes and window helpers for the array walk engine.
package array_walk_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam logic MODE_FILL  = 1'b0;
    localparam logic MODE_SHIFT = 1'b1;

    // Last index actually walked: hi clamped to the top of the array.
    function automatic int unsigned win_end(int unsigned hi, int unsigned depth);
        return (hi > depth - 1) ? depth - 1 : hi;
    endfunction

    function automatic logic win_empty(int unsigned lo, int unsigned hi, int unsigned depth);
        return (lo >= depth) || (lo > win_end(hi, depth));
    endfunction

    function automatic logic idx_ok(int unsigned idx, int unsigned depth);
        return idx < depth;
    endfunction

endpackage

// File: rtl/array_walk_ctrl.sv
// Walker FSM: accepts commands, steps the index one element per clock and counts writes.
module array_walk_ctrl
    import array_walk_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          mode_i,
    input  logic [IW-1:0] lo_i,
    input  logic [IW-1:0] hi_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          accept_o,
    output logic          we_o,
    output logic          mode_o,
    output logic [IW-1:0] widx_o,
    output logic [IW:0]   wr_count_o,
    output state_t        state_o
);

    state_t      state_q, state_d;
    logic [IW:0] idx_q, idx_d;
    logic [IW:0] end_q, end_d;
    logic [IW:0] cnt_q, cnt_d;
    logic        mode_q, mode_d;
    logic [IW:0] lo_w, end_w;
    logic        empty_w;

    // Index arithmetic is one bit wider than the array index so stepping never wraps.
    assign lo_w    = {1'b0, lo_i};
    assign end_w   = (IW+1)'(win_end(32'(hi_i), DEPTH));
    assign empty_w = win_empty(32'(lo_i), 32'(hi_i), DEPTH);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        end_d   = end_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    mode_d = mode_i;
                    cnt_d  = '0;
                    if (empty_w) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                        idx_d   = (mode_i == MODE_SHIFT) ? end_w : lo_w;
                        end_d   = (mode_i == MODE_SHIFT) ? lo_w : end_w;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (idx_q == end_q) begin
                    state_d = ST_DONE;
                end else if (mode_q == MODE_SHIFT) begin
                    idx_d = idx_q - 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            end_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_FILL;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            end_q   <= end_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = (state_q == ST_DONE);
    assign accept_o   = (state_q == ST_IDLE) && start_i;
    assign we_o       = (state_q == ST_RUN);
    assign mode_o     = mode_q;
    assign widx_o     = idx_q[IW-1:0];
    assign wr_count_o = cnt_q;
    assign state_o    = state_q;

endmodule

// File: rtl/array_walk_engine.sv
// Register array with host read/write port and a sequential FILL/SHIFT walker.
module array_walk_engine
    import array_walk_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 4,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [IW-1:0]    wr_idx_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [IW-1:0]    rd_idx_i,
    output logic [WIDTH-1:0] rd_data_o,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [IW-1:0]    lo_i,
    input  logic [IW-1:0]    hi_i,
    input  logic [IW-1:0]    src_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [IW:0]      wr_count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] snap_q, snap_d;
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] walk_data;
    logic             host_we, walk_we, accept, walk_mode;
    logic [IW-1:0]    widx, widx_prev;
    state_t           state;

    array_walk_ctrl #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_ctrl (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .mode_i     (mode_i),
        .lo_i       (lo_i),
        .hi_i       (hi_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .accept_o   (accept),
        .we_o       (walk_we),
        .mode_o     (walk_mode),
        .widx_o     (widx),
        .wr_count_o (wr_count_o),
        .state_o    (state)
    );

    assign host_we = (state == ST_IDLE) && wr_en_i && idx_ok(32'(wr_idx_i), DEPTH);

    // A host write landing on src in the accept cycle must be seen by the snapshot.
    always_comb begin
        snap_d = '0;
        if (host_we && (wr_idx_i == src_i)) begin
            snap_d = wr_data_i;
        end else if (idx_ok(32'(src_i), DEPTH)) begin
            snap_d = mem_q[src_i];
        end
    end

    assign widx_prev = widx - 1'b1;

    always_comb begin
        walk_data = snap_q;
        if (walk_mode == MODE_SHIFT) begin
            walk_data = (widx == '0) ? '0 : mem_q[widx_prev];
        end
    end

    // Storage is deliberately not reset; walker and host writes are mutually exclusive by state.
    always_ff @(posedge clk_i) begin
        if (walk_we) begin
            mem_q[widx] <= walk_data;
        end else if (host_we) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            snap_q    <= '0;
            rd_data_q <= '0;
        end else begin
            if (accept) begin
                snap_q <= snap_d;
            end
            rd_data_q <= idx_ok(32'(rd_idx_i), DEPTH) ? mem_q[rd_idx_i] : '0;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: doc/array_walk_engine.md
Name: array_walk_engine

Overview:
- Parametrised register-array block holding DEPTH words of WIDTH bits.
- A sequential index walker rewrites a programmable index range one element per clock. It replaces combinational for-loops over arrays whose bounds or conditions cannot be resolved at elaboration.
- A host port gives direct word write/read access. The walker supports FILL and SHIFT modes over an arbitrary [lo, hi] window, including empty windows.
- It sits beside test logic as a self-checking memory fixture.

Parameters:
- WIDTH, 4, bits per array word.
- DEPTH, 4, number of words (>= 2, need not be a power of two).
- IW, $clog2(DEPTH), index width (derived, not overridden).

Ports:
- clk  in  1  sole clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  host write strobe.
- wr_idx  in  IW  host write index.
- wr_data  in  WIDTH  host write data.
- rd_idx  in  IW  host read index.
- rd_data  out  WIDTH  registered read data.
- start  in  1  command strobe.
- mode  in  1  0 = FILL, 1 = SHIFT.
- lo  in  IW  first index of window.
- hi  in  IW  last index of window.
- src  in  IW  FILL source index.
- busy  out  1  walker active.
- done  out  1  one-cycle completion pulse.
- wr_count  out  IW+1  number of element writes performed by the last command.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - rd_data, busy, done, wr_count and the internal index/snapshot registers all go to 0.
  - Array contents are not reset; they are undefined until written.
- rd_data: 1-cycle latency, always reflects array[rd_idx] as of the previous edge. It is valid in every state. rd_idx >= DEPTH returns 0.
- Host write:
  - Honoured only in IDLE; ignored while busy.
  - wr_idx >= DEPTH is ignored.
  - A write and start in the same IDLE cycle: the write commits first, and the command sees the written value.
- Command acceptance:
  - start is accepted only in IDLE; it is ignored while busy.
  - The effective window is lo..min(hi, DEPTH-1).
  - The window is empty if lo > min(hi, DEPTH-1) or lo >= DEPTH.
- State machine, states IDLE, RUN, DONE:
  - IDLE, accepted start, empty window -> DONE. No writes; wr_count loads 0.
  - IDLE, accepted start, non-empty window -> RUN. wr_count clears.
  - RUN: exactly one array write per cycle. wr_count increments per write. Moves to DONE after the last index.
  - DONE: done=1 for one cycle, then -> IDLE.
  - busy = (state != IDLE).
  - For N elements: busy is high for N+1 cycles, and done is asserted in the cycle after the last write.
- FILL mode:
  - The index walks ascending from lo to hi.
  - At acceptance, array[src] is snapshotted into a WIDTH register; every window element receives the snapshot.
  - src inside the window is allowed; the snapshot prevents mid-walk corruption.
  - src >= DEPTH snapshots 0.
- SHIFT mode:
  - The index walks descending from hi to lo; each step writes array[i] <= array[i-1].
  - At i == 0 it writes 0.
  - Descending order guarantees every element receives its pre-command neighbour value.
- Index arithmetic:
  - Compare and step in IW+1 bits, so descending past index 0 and ascending to DEPTH never wrap.
  - Loop termination uses equality with the stored end index, not a range test.
- Reset mid-RUN:
  - The walk aborts immediately with no further writes.
  - Elements already written keep their new values.
- Command inputs (mode, lo, hi, src) are sampled only at acceptance; later changes have no effect.

Decomposition:
- Package array_walk_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - mode constants MODE_FILL = 1'b0, MODE_SHIFT = 1'b1;
  - a function computing the effective end index and empty flag from lo, hi and DEPTH.
- One sub-module, array_walk_ctrl, contains the FSM, index register, end register, wr_count and write-enable generation.
- The top level contains the storage array, snapshot register, host ports and read register.

Test Plan:
- WIDTH=4, DEPTH=4. Host writes array = {0:1, 1:1, 2:2, 3:3}; FILL lo=2 hi=3 src=0 -> busy 3 cycles, done pulse; reads give {1, 1, 1, 1}; wr_count=2.
- Same preload; SHIFT lo=0 hi=3 -> array = {0, 1, 1, 2}; wr_count=4; busy 5 cycles.
- Empty window lo=3 hi=1 (the "i<4 && i>1" style condition that is never true at i=0) -> no writes; done one cycle after start; wr_count=0; array unchanged; busy 1 cycle.
- hi=7 clamped (DEPTH=4), FILL lo=1 src=3 with array[3]=4'hA -> indices 1..3 = 4'hA; wr_count=3. A concurrent start and wr_en issued during busy are both ignored.
- Assert rst two cycles into a SHIFT of lo=0 hi=3 -> busy=0, done=0 and wr_count=0 immediately (async). Only index 3, and possibly index 2, are modified. A subsequent FILL works normally.
- Parameter sweep WIDTH=8, DEPTH=5 -> FILL lo=0 hi=4 src=4 = 8'h5A fills all five words; rd_idx=5 returns 0.
